ahb_slave_arbiter: RTL and testbench
====================================

Name: ahb_slave_arbiter

Overview:
- Per-slave-port arbiter that shares one AHB slave between CHANNEL_NUM masters.
- Drives the one-hot select of the slave-side payload mux.
- Two selects are produced:
  - sel_addr: which master owns the address/control phase.
  - sel_data: which master owns the data/response phase; it lags sel_addr by one accepted transfer.
- Round-robin fairness, lock support, and a beat cap that prevents one master from monopolising the slave.

Parameters:
- CHANNEL_NUM, 2, number of masters sharing this slave (2..16).
- MAX_HOLD, 16, beats a master may keep the grant while others request; 0 = unlimited.
- CNT_W, 5, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- hclk  input  1  system clock, rising edge.
- hreset_n  input  1  asynchronous active-low reset.
- hreq  input  CHANNEL_NUM  per-master request for this slave (address decoded to this slave).
- hlock  input  CHANNEL_NUM  per-master locked-sequence indicator.
- htrans  input  CHANNEL_NUM x 2  per-master HTRANS: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hready_in  input  1  slave HREADY; a transfer is accepted on a rising edge with hready_in=1.
- sel_addr  output  CHANNEL_NUM  one-hot address-phase owner; all-zero when no owner.
- sel_data  output  CHANNEL_NUM  one-hot data-phase owner; drives the slave mux sel.
- hmaster  output  4  binary index of the sel_addr owner; 0 when no owner.
- grant_valid  output  1  1 when sel_addr is non-zero.

Behaviour:
- Reset (asynchronous, hreset_n=0): sel_addr=0, sel_data=0, hmaster=0, grant_valid=0, state=NO_OWNER, hold_cnt=0, rr_ptr=CHANNEL_NUM-1 (so master 0 wins the first arbitration).
  - Reset mid-burst drops ownership immediately, with no completion.
- All outputs are registered; nothing is combinational from inputs to outputs.
- States:
  - NO_OWNER:
    - On any edge with hready_in=1 and |hreq, grant the winner and go to OWNED.
    - Otherwise stay.
  - OWNED:
    - Re-arbitration point (RP) = edge with hready_in=1 and hlock[owner]=0 and either:
      - htrans[owner] in {IDLE, NONSEQ} and hreq[owner]=0, or
      - cap reached, see below.
    - At an RP:
      - If any other master requests, grant the round-robin winner among the others.
      - Else if hreq[owner]=0, go to NO_OWNER (sel_addr=0).
      - Else keep the owner.
    - hready_in=0: nothing changes (grant, counter, pointer all frozen).
- Round-robin: search indices rr_ptr+1, rr_ptr+2, ... modulo CHANNEL_NUM. The first requester found wins. rr_ptr is loaded with the winner index on each new grant.
- Burst integrity: no ownership change while htrans[owner] is SEQ or BUSY.
- Hold counter:
  - Cleared on each new grant.
  - Incremented (saturating) on each accepted edge where htrans[owner] is NONSEQ or SEQ.
  - Cap reached = MAX_HOLD!=0 and hold_cnt>=MAX_HOLD and another master requests and htrans[owner] in {IDLE, NONSEQ}.
    - The cap forces handover only at a burst boundary.
    - hlock[owner]=1 suppresses the cap.
- Grant latency: the new sel_addr/hmaster/grant_valid is visible in the cycle after the deciding edge.
- sel_data:
  - On every edge with hready_in=1: sel_data <= sel_addr (the pre-update value). This yields exactly one accepted-transfer lag.
  - hready_in=0: sel_data holds, so the pending response stays routed to its master during wait states.
- Simultaneous requests on the first grant: the lowest index at or after rr_ptr+1 wins.
- A request deasserted at the same edge it would win is not granted (sampled value rules).

Test Plan:
- Reset, then hreq=2'b11, hready_in=1 → next cycle sel_addr=01, hmaster=0. After the next accepted edge sel_data=01.
- Master 0 issues NONSEQ+3×SEQ with hreq[0] dropped after NONSEQ and hreq[1]=1 → sel_addr stays 01 through all SEQ beats. sel_addr=10 the cycle after the edge where htrans[0]=IDLE. sel_data switches one accepted edge later.
- hready_in=0 for 3 cycles at a handover edge → sel_addr and sel_data both frozen. Switch occurs only after hready_in returns to 1.
- MAX_HOLD=4, master 0 back-to-back NONSEQ singles with hreq[0]=1, hreq[1]=1 → after 4 accepted beats, grant moves to master 1. Master 1 then holds; the cap returns the grant to 0 after 4 of its beats.
- hlock[0]=1 with MAX_HOLD=4, master 0 issuing 10 beats, hreq[1]=1 → no handover until hlock[0]=0 at an IDLE/NONSEQ boundary.
- CHANNEL_NUM=4, rr_ptr=2, hreq=4'b1011 at an RP → winner 3. Next RP with same requests → winner 0. Assert hreset_n=0 mid-burst → all outputs 0 asynchronously, and master 0 wins first after release.

Source files
------------

// File: rtl/ahb_slave_arbiter.sv
// Purpose : round-robin arbiter sharing one AHB slave among CHANNEL_NUM masters, with lock and beat cap.
// Latency : one cycle; a grant decided on an accepted edge is visible on sel_addr/hmaster the next cycle.
// Backpres: hready_in=0 freezes grant, hold counter, rr pointer and sel_data (response stays routed).
// Ports   : hclk/hreset_n clock and async active-low reset; hreq/hlock/htrans per-master request,
//           lock and HTRANS; hready_in slave HREADY; sel_addr/sel_data one-hot address/data owners;
//           hmaster binary address owner; grant_valid high while an address owner exists.
module ahb_slave_arbiter #(
   parameter int CHANNEL_NUM = 2,
   parameter int MAX_HOLD    = 16,
   parameter int CNT_W       = 5
) (
   input  logic                        hclk,
   input  logic                        hreset_n,
   input  logic [CHANNEL_NUM-1:0]      hreq,
   input  logic [CHANNEL_NUM-1:0]      hlock,
   input  logic [CHANNEL_NUM-1:0][1:0] htrans,
   input  logic                        hready_in,
   output logic [CHANNEL_NUM-1:0]      sel_addr,
   output logic [CHANNEL_NUM-1:0]      sel_data,
   output logic [3:0]                  hmaster,
   output logic                        grant_valid
);

   localparam logic [1:0]       TR_IDLE   = 2'b00;
   localparam logic [1:0]       TR_NONSEQ = 2'b10;
   localparam logic [1:0]       TR_SEQ    = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {NO_OWNER, OWNED} state_t;

   state_t                   state_q, state_d;
   logic [3:0]               owner_q, owner_d;
   logic [3:0]               rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]         hold_cnt_q, hold_cnt_d;
   logic [CHANNEL_NUM-1:0]   sel_addr_d, sel_data_d;
   logic                     grant_valid_d;

   // Zero-extended copies so a 4-bit owner/pointer index never exceeds the vector width.
   logic [15:0]              hreq_ext, hlock_ext;
   logic [1:0]               own_trans;
   logic                     own_req, own_lock, boundary, cap_hit, rp;
   logic                     win_any_vld, win_oth_vld, new_grant;
   logic [3:0]               win_any, win_oth, grant_idx;
   logic [4:0]               idx;

   assign hreq_ext  = 16'(hreq);
   assign hlock_ext = 16'(hlock);
   assign own_req   = hreq_ext[owner_q];
   assign own_lock  = hlock_ext[owner_q];

   always_comb begin
      own_trans = TR_IDLE;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         if (owner_q == 4'(i)) own_trans = htrans[i];
      end
   end

   // Round-robin search starting just after the last grantee. win_any ignores ownership
   // (used from NO_OWNER); win_oth skips the current owner (used at re-arbitration points).
   always_comb begin
      win_any_vld = 1'b0;
      win_any     = '0;
      win_oth_vld = 1'b0;
      win_oth     = '0;
      idx         = '0;
      for (int k = 1; k <= CHANNEL_NUM; k++) begin
         idx = {1'b0, rr_ptr_q} + 5'(k);
         if (idx >= 5'(CHANNEL_NUM)) idx = idx - 5'(CHANNEL_NUM);
         if (!win_any_vld && hreq_ext[idx[3:0]]) begin
            win_any_vld = 1'b1;
            win_any     = idx[3:0];
         end
         if (!win_oth_vld && hreq_ext[idx[3:0]] && (idx[3:0] != owner_q)) begin
            win_oth_vld = 1'b1;
            win_oth     = idx[3:0];
         end
      end
   end

   // Handover is only allowed at a burst boundary; the cap only bites when someone else waits.
   assign boundary = (own_trans == TR_IDLE) || (own_trans == TR_NONSEQ);
   assign cap_hit  = (MAX_HOLD != 0) && (hold_cnt_q >= CNT_W'(MAX_HOLD)) && win_oth_vld && boundary;
   assign rp       = hready_in && !own_lock && ((boundary && !own_req) || cap_hit);

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      hold_cnt_d    = hold_cnt_q;
      sel_addr_d    = sel_addr;
      grant_valid_d = grant_valid;
      new_grant     = 1'b0;
      grant_idx     = '0;
      if (hready_in) begin
         if (state_q == NO_OWNER) begin
            if (win_any_vld) begin
               new_grant = 1'b1;
               grant_idx = win_any;
            end
         end else begin
            if (rp && win_oth_vld) begin
               new_grant = 1'b1;
               grant_idx = win_oth;
            end else if (rp && !own_req) begin
               state_d       = NO_OWNER;
               owner_d       = '0;
               hold_cnt_d    = '0;
               sel_addr_d    = '0;
               grant_valid_d = 1'b0;
            end else if (((own_trans == TR_NONSEQ) || (own_trans == TR_SEQ)) && (hold_cnt_q != CNT_MAX)) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
      end
      if (new_grant) begin
         state_d       = OWNED;
         owner_d       = grant_idx;
         rr_ptr_d      = grant_idx;
         hold_cnt_d    = '0;
         grant_valid_d = 1'b1;
         for (int i = 0; i < CHANNEL_NUM; i++) sel_addr_d[i] = (grant_idx == 4'(i));
      end
   end

   // Data phase follows the address owner of the previously accepted transfer.
   assign sel_data_d = hready_in ? sel_addr : sel_data;

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q     <= NO_OWNER;
         owner_q     <= '0;
         rr_ptr_q    <= 4'(CHANNEL_NUM - 1);
         hold_cnt_q  <= '0;
         sel_addr    <= '0;
         sel_data    <= '0;
         grant_valid <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         sel_addr    <= sel_addr_d;
         sel_data    <= sel_data_d;
         grant_valid <= grant_valid_d;
      end
   end

   assign hmaster = owner_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Purpose : directed bench for ahb_slave_arbiter (4 masters, beat cap 4) with a behavioural model.
// Latency : model updates on each rising edge; outputs compared on every falling edge.
// Backpres: hready_in stalls are part of the directed stimulus.
module tb_ahb_slave_arbiter;

   localparam int CH = 4;
   localparam int MH = 4;
   localparam int CW = 3;
   localparam logic [1:0] I  = 2'b00;
   localparam logic [1:0] NS = 2'b10;
   localparam logic [1:0] SQ = 2'b11;

   logic               hclk = 1'b0;
   logic               hreset_n;
   logic [CH-1:0]      hreq, hlock;
   logic [CH-1:0][1:0] htrans;
   logic               hready_in;
   logic [CH-1:0]      sel_addr, sel_data;
   logic [3:0]         hmaster;
   logic               grant_valid;

   int n_cmp = 0;
   int n_err = 0;

   ahb_slave_arbiter #(.CHANNEL_NUM(CH), .MAX_HOLD(MH), .CNT_W(CW)) dut (
      .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock), .htrans(htrans),
      .hready_in(hready_in), .sel_addr(sel_addr), .sel_data(sel_data),
      .hmaster(hmaster), .grant_valid(grant_valid)
   );

   always #5 hclk = ~hclk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic logic [CH-1:0] oh(input int m);
      return (m < 0) ? '0 : (CH'(1) << m);
   endfunction

   function automatic bit bit_of(input logic [CH-1:0] v, input int i);
      return ((v >> i) & CH'(1)) != '0;
   endfunction

   // Model: owner as an integer (-1 = none), beats held, last grantee, data-phase owner.
   int m_owner, m_ptr, m_cnt, m_data;

   always @(posedge hclk or negedge hreset_n) begin
      int win, t, i;
      bit bnd, cap, rp;
      if (!hreset_n) begin
         m_owner = -1;
         m_ptr   = CH - 1;
         m_cnt   = 0;
         m_data  = -1;
      end else if (hready_in) begin
         m_data = m_owner;
         win = -1;
         for (int k = 1; k <= CH; k++) begin
            i = (m_ptr + k) % CH;
            if (win < 0 && bit_of(hreq, i) && i != m_owner) win = i;
         end
         if (m_owner < 0) begin
            if (win >= 0) begin
               m_owner = win; m_ptr = win; m_cnt = 0;
            end
         end else begin
            t   = int'((htrans >> (2 * m_owner)) & 8'h3);
            bnd = (t == 0) || (t == 2);
            cap = (MH != 0) && (m_cnt >= MH) && (win >= 0) && bnd;
            rp  = !bit_of(hlock, m_owner) && ((bnd && !bit_of(hreq, m_owner)) || cap);
            if (rp && win >= 0) begin
               m_owner = win; m_ptr = win; m_cnt = 0;
            end else if (rp && !bit_of(hreq, m_owner)) begin
               m_owner = -1; m_cnt = 0;
            end else if (t >= 2) begin
               m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
            end
         end
      end
   end

   always @(negedge hclk) begin
      chk("cyc_sel_addr", int'(sel_addr), int'(oh(m_owner)));
      chk("cyc_sel_data", int'(sel_data), int'(oh(m_data)));
      chk("cyc_hmaster", int'(hmaster), (m_owner < 0) ? 0 : m_owner);
      chk("cyc_grant_valid", int'(grant_valid), (m_owner >= 0) ? 1 : 0);
   end

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      hreset_n = 1'b0; hreq = '0; hlock = '0; htrans = '0; hready_in = 1'b0;
      #3;
      chk("rst_sel_addr", int'(sel_addr), 0);
      chk("rst_sel_data", int'(sel_data), 0);
      chk("rst_hmaster", int'(hmaster), 0);
      chk("rst_grant_valid", int'(grant_valid), 0);
      tick();
      hreset_n = 1'b1;

      // Simultaneous first requests: master 0 wins, data phase follows one edge later.
      hreq = 4'b0011; hready_in = 1'b1; htrans = {I, I, I, I};
      tick();
      chk("first_sel_addr", int'(sel_addr), 1);
      chk("first_hmaster", int'(hmaster), 0);
      chk("first_sel_data", int'(sel_data), 0);
      tick();
      chk("first_data_follow", int'(sel_data), 1);

      // Burst integrity: NONSEQ + 3 SEQ with hreq[0] dropped, master 1 waiting.
      htrans = {I, I, I, NS};
      tick();
      chk("burst_ns", int'(sel_addr), 1);
      hreq = 4'b0010; htrans = {I, I, I, SQ};
      for (int b = 0; b < 3; b++) begin
         tick();
         chk("burst_seq_hold", int'(sel_addr), 1);
      end
      htrans = {I, I, I, I};
      tick();
      chk("burst_end_sel_addr", int'(sel_addr), 2);
      chk("burst_end_hmaster", int'(hmaster), 1);
      chk("burst_end_sel_data", int'(sel_data), 1);

      // Wait states at a handover edge freeze both selects.
      hreq = 4'b0001; hready_in = 1'b0;
      for (int w = 0; w < 3; w++) begin
         tick();
         chk("wait_sel_addr", int'(sel_addr), 2);
         chk("wait_sel_data", int'(sel_data), 1);
      end
      hready_in = 1'b1;
      tick();
      chk("wait_release_sel_addr", int'(sel_addr), 1);
      chk("wait_release_sel_data", int'(sel_data), 2);
      tick();
      chk("wait_release_data_follow", int'(sel_data), 1);

      // Beat cap: 4 NONSEQ singles, then the other requester gets the slave, and back.
      hreq = 4'b0011; htrans = {I, I, I, NS};
      for (int b = 0; b < 4; b++) begin
         tick();
         chk("cap0_hold", int'(sel_addr), 1);
      end
      tick();
      chk("cap0_switch", int'(sel_addr), 2);
      htrans = {I, I, NS, I};
      for (int b = 0; b < 4; b++) begin
         tick();
         chk("cap1_hold", int'(sel_addr), 2);
      end
      tick();
      chk("cap1_switch", int'(sel_addr), 1);

      // Lock suppresses the cap until released at a NONSEQ boundary.
      htrans = {I, I, I, NS}; hlock = 4'b0001;
      for (int b = 0; b < 10; b++) begin
         tick();
         chk("lock_hold", int'(sel_addr), 1);
      end
      hlock = 4'b0000;
      tick();
      chk("lock_release", int'(sel_addr), 2);

      // Round-robin order with 4 masters: last grantee 2, requests 1011 -> 3, then 0.
      htrans = {I, I, I, I}; hreq = 4'b0100;
      tick();
      chk("rr_to2_hmaster", int'(hmaster), 2);
      hreq = 4'b1011;
      tick();
      chk("rr_to3_sel_addr", int'(sel_addr), 8);
      chk("rr_to3_hmaster", int'(hmaster), 3);
      htrans = {NS, I, I, I};
      for (int b = 0; b < 4; b++) tick();
      chk("rr_pre_wrap", int'(hmaster), 3);
      tick();
      chk("rr_wrap_sel_addr", int'(sel_addr), 1);
      chk("rr_wrap_hmaster", int'(hmaster), 0);

      // Asynchronous reset in the middle of a burst.
      htrans = {I, I, I, NS};
      tick();
      htrans = {I, I, I, SQ};
      tick();
      chk("midburst_owner", int'(sel_addr), 1);
      hreset_n = 1'b0;
      #2;
      chk("arst_sel_addr", int'(sel_addr), 0);
      chk("arst_sel_data", int'(sel_data), 0);
      chk("arst_hmaster", int'(hmaster), 0);
      chk("arst_grant_valid", int'(grant_valid), 0);
      tick();
      hreq = 4'b1111; htrans = {I, I, I, I};
      hreset_n = 1'b1;
      tick();
      chk("post_rst_sel_addr", int'(sel_addr), 1);
      chk("post_rst_hmaster", int'(hmaster), 0);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
